// File: rtl/hamming_pkg.sv
// Shared definitions for the streaming Hamming encoder and its decoder.
//   calc_r(k)   : number of Hamming parity bits needed for k data bits.
//   data_pos(i) : Hamming position (1-based) of data bit i; powers of two
//                 are reserved for parity, so data fills 3, 5, 6, 7, 9, ...
//   occ_e       : occupancy of the encoder's two-entry output buffer.
package hamming_pkg;

    localparam int MAX_K = 64;
    localparam int MAX_N = 72;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    // Smallest r with 2^r >= k + r + 1. The bounded loop keeps this usable
    // as a constant function by synthesis tools.
    function automatic int calc_r(input int k);
        int r;
        r = 1;
        for (int c = 0; c < 8; c++) begin
            if ((1 << r) < (k + r + 1)) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

    // Position of data bit i: the i-th position that is not a power of two.
    function automatic int data_pos(input int i);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int p = 3; p <= MAX_N; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == i) begin
                    pos = p;
                end
                cnt = cnt + 1;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/hamming_parity_gen.sv
// Combinational Hamming codeword generator.
//   data_i     [K-1:0] : data word
//   codeword_o [N-1:0] : {overall parity (SECDED only), parity[R-1:0], data}
// parity[j] is the XOR of every data bit whose Hamming position has bit j
// set. With SECDED the top bit makes the whole codeword even weight.
module hamming_parity_gen
    import hamming_pkg::*;
#(
    parameter int K      = 4,
    parameter int SECDED = 0,
    localparam int R     = calc_r(K),
    localparam int N     = K + R + SECDED
) (
    input  logic [K-1:0] data_i,
    output logic [N-1:0] codeword_o
);

    logic [R-1:0] parity;

    always_comb begin
        parity = '0;
        for (int j = 0; j < R; j++) begin
            for (int i = 0; i < K; i++) begin
                if (((data_pos(i) >> j) & 1) != 0) begin
                    parity[j] = parity[j] ^ data_i[i];
                end
            end
        end
    end

    if (SECDED != 0) begin : g_secded
        assign codeword_o = {^{parity, data_i}, parity, data_i};
    end else begin : g_sec
        assign codeword_o = {parity, data_i};
    end

endmodule

// File: rtl/hamming_stream_encoder.sv
// Streaming Hamming (SEC) / extended Hamming (SECDED) encoder.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : input handshake, in_data [K-1:0], inj_mask [N-1:0]
//   out_valid/out_ready   : output handshake, out_codeword [N-1:0]
//   enc_count [CNT_W-1:0] : codewords delivered, wraps
//   dbg_state [1:0]       : buffer occupancy (occ_e encoding)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid, once raised, holds its payload until that edge, and the
// payload never changes while valid is high and ready is low.
//
// Buffering: OR drives the output, SK catches the word accepted while OR is
// stalled. in_ready is a flop computed from the next occupancy, so it has no
// combinational path from out_ready; the skid entry makes that safe.
module hamming_stream_encoder
    import hamming_pkg::*;
#(
    parameter int K      = 4,
    parameter int SECDED = 0,
    parameter int CNT_W  = 16,
    localparam int R     = calc_r(K),
    localparam int N     = K + R + SECDED
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [K-1:0]     in_data,
    input  logic [N-1:0]     inj_mask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_codeword,
    output logic [CNT_W-1:0] enc_count,
    output logic [1:0]       dbg_state
);

    occ_e             state_q, state_d;
    logic [N-1:0]     or_q, or_d;
    logic [N-1:0]     sk_q, sk_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [N-1:0]     enc_cw;
    logic [N-1:0]     new_word;
    logic             accept;
    logic             deliver;

    hamming_parity_gen #(
        .K      (K),
        .SECDED (SECDED)
    ) u_parity_gen (
        .data_i     (in_data),
        .codeword_o (enc_cw)
    );

    assign new_word = enc_cw ^ inj_mask;
    assign accept   = in_valid & in_ready_q;
    assign deliver  = out_valid_q & out_ready;

    always_comb begin
        state_d = state_q;
        or_d    = or_q;
        sk_d    = sk_q;
        unique case (state_q)
            OCC_EMPTY: begin
                if (accept) begin
                    or_d    = new_word;
                    state_d = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (accept && deliver) begin
                    or_d = new_word;
                end else if (accept) begin
                    sk_d    = new_word;
                    state_d = OCC_FULL;
                end else if (deliver) begin
                    state_d = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                // in_ready is low here, so only a deliver can happen.
                if (deliver) begin
                    or_d    = sk_q;
                    state_d = OCC_ONE;
                end
            end
            default: begin
                state_d = OCC_EMPTY;
            end
        endcase
        in_ready_d  = (state_d != OCC_FULL);
        out_valid_d = (state_d != OCC_EMPTY);
        cnt_d       = cnt_q + CNT_W'(deliver);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= OCC_EMPTY;
            or_q        <= '0;
            sk_q        <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            or_q        <= or_d;
            sk_q        <= sk_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_codeword = or_q;
    assign enc_count    = cnt_q;
    assign dbg_state    = state_q;

endmodule
